// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and mul/div structural stalls,
// taken-branch flushes, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W      = 3,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegRt,
    input  logic [REG_W-1:0] IFIDrs,
    input  logic [REG_W-1:0] IFIDrt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_IsMulDiv,
    input  logic             IFID_IsHiLo,
    input  logic             muldiv_start,
    input  logic             muldiv_op,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [7:0] MUL_LAT = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES);

    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             md_active;
    logic             lu_hazard;
    logic             md_hazard;

    always_comb begin
        md_active = (md_cnt_q != '0);

        // Register 0 is hard-wired, so a load targeting it can never be a hazard.
        lu_hazard = IDEX_MemRead && (IDEX_RegRt != '0) &&
                    ((IDEX_RegRt == IFIDrs) || (IFID_UsesRt && (IDEX_RegRt == IFIDrt)));
        md_hazard = (md_active || muldiv_start) && (IFID_IsHiLo || IFID_IsMulDiv);

        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        muldiv_busy = md_active;
        muldiv_done = (md_cnt_q == 8'd1);

        if (rst) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
            muldiv_busy = 1'b0;
            muldiv_done = 1'b0;
        end else if (branch_taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (md_hazard || lu_hazard) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_Bubble = 1'b1;
        end

        // A start while already busy is ignored; the running operation continues.
        md_cnt_d = md_cnt_q;
        if (rst) begin
            md_cnt_d = '0;
        end else if (muldiv_start && !md_active) begin
            md_cnt_d = muldiv_op ? DIV_LAT : MUL_LAT;
        end else if (md_active) begin
            md_cnt_d = md_cnt_q - 8'd1;
        end

        stall_cycles_d = stall_cycles_q;
        if (rst) begin
            stall_cycles_d = '0;
        end else if (!PCWrite && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        md_cnt_q       <= md_cnt_d;
        stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic,
// compared every cycle against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        IDEX_MemRead;
    logic [2:0]  IDEX_RegRt, IFIDrs, IFIDrt;
    logic        IFID_UsesRt, IFID_IsMulDiv, IFID_IsHiLo;
    logic        muldiv_start, muldiv_op, branch_taken;
    logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush;
    logic        muldiv_busy, muldiv_done;
    logic [15:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Model state: remaining busy cycles and the stall count (unbounded, clipped on compare).
    int md_left = 0;
    int stalls  = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_W(3), .MUL_CYCLES(4), .DIV_CYCLES(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRt(IDEX_RegRt),
        .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_IsMulDiv(IFID_IsMulDiv), .IFID_IsHiLo(IFID_IsHiLo),
        .muldiv_start(muldiv_start), .muldiv_op(muldiv_op),
        .branch_taken(branch_taken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cycles(stall_cycles)
    );

    task automatic idle();
        rst = 0; IDEX_MemRead = 0; IDEX_RegRt = 0; IFIDrs = 0; IFIDrt = 0;
        IFID_UsesRt = 0; IFID_IsMulDiv = 0; IFID_IsHiLo = 0;
        muldiv_start = 0; muldiv_op = 0; branch_taken = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the current inputs for one clock: checks outputs mid-cycle, then advances the model.
    task automatic step(input string tag);
        bit hazard_lu, hazard_md, stall, busy;
        logic [6:0] exp_ctl;
        int sat;
        busy = (md_left > 0);
        hazard_lu = IDEX_MemRead && IDEX_RegRt != 0 &&
                    (IDEX_RegRt == IFIDrs || (IFID_UsesRt && IDEX_RegRt == IFIDrt));
        hazard_md = (busy || muldiv_start) && (IFID_IsHiLo || IFID_IsMulDiv);
        stall = !rst && !branch_taken && (hazard_lu || hazard_md);
        // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, IDEX_Flush, busy, done}
        if (rst)               exp_ctl = 7'b0010000;
        else if (branch_taken) exp_ctl = {5'b11011, busy, md_left == 1};
        else if (stall)        exp_ctl = {5'b00100, busy, md_left == 1};
        else                   exp_ctl = {5'b11000, busy, md_left == 1};
        assert (!(muldiv_start && busy && !rst))
            else $error("illegal muldiv_start while busy in %s", tag);
        @(negedge clk);
        sat = (stalls > 65535) ? 65535 : stalls;
        check({tag, ".ctl"}, 32'({PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush,
                                  IDEX_Flush, muldiv_busy, muldiv_done}), 32'(exp_ctl));
        check({tag, ".cnt"}, 32'(stall_cycles), 32'(sat));
        if (rst) begin
            md_left = 0; stalls = 0;
        end else begin
            if (muldiv_start && md_left == 0) md_left = muldiv_op ? 8 : 4;
            else if (md_left > 0) md_left--;
            if (stall) stalls++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(); rst = 1;
        step("reset0");
        step("reset1");
        check("reset_cnt", 32'(stall_cycles), 32'd0);

        // Load-use on rs: one stall, then forwarding takes over.
        idle(); IDEX_MemRead = 1; IDEX_RegRt = 3; IFIDrs = 3;
        step("lu_rs");
        idle(); IFIDrs = 3;
        step("lu_after");
        check("lu_cnt", 32'(stall_cycles), 32'd1);

        // Load to r0 is never a hazard; rt match without UsesRt is not either.
        idle(); IDEX_MemRead = 1;
        step("lu_r0");
        idle(); IDEX_MemRead = 1; IDEX_RegRt = 5; IFIDrt = 5;
        step("rt_unused");
        IFID_UsesRt = 1;
        step("rt_used");

        // Divide with dependent mfhi held in ID: 9 stalls total.
        idle(); rst = 1; step("rst_div");
        idle(); muldiv_start = 1; muldiv_op = 1; IFID_IsHiLo = 1;
        step("div_start");
        muldiv_start = 0;
        for (int i = 0; i < 8; i++) step($sformatf("div_busy%0d", i + 1));
        step("div_release");
        check("div_cnt", 32'(stall_cycles), 32'd9);

        // Independent multiply: busy 4 cycles, no stall.
        idle(); muldiv_start = 1;
        step("mul_start");
        muldiv_start = 0;
        for (int i = 0; i < 5; i++) step($sformatf("mul_run%0d", i));

        // Branch overrides a load-use hazard.
        idle(); IDEX_MemRead = 1; IDEX_RegRt = 2; IFIDrs = 2; branch_taken = 1;
        step("br_lu");
        check("br_cnt", 32'(stall_cycles), 32'd9);

        // Branch while a multiply runs does not cancel it.
        idle(); muldiv_start = 1; step("mulbr_start");
        idle(); branch_taken = 1; IFID_IsMulDiv = 1; step("mulbr_br");
        idle(); IFID_IsMulDiv = 1; step("mulbr_after1");
        step("mulbr_after2");
        idle(); step("mulbr_end");

        // Reset in the second busy cycle of a multiply.
        idle(); muldiv_start = 1; step("rstmul_start");
        idle(); step("rstmul_b1");
        rst = 1; step("rstmul_b2");
        idle(); step("rstmul_post");
        check("rstmul_cnt", 32'(stall_cycles), 32'd0);

        // Random traffic with occasional reset; starts only when the model is idle.
        for (int i = 0; i < 600; i++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            IDEX_MemRead = $urandom_range(0, 1);
            IDEX_RegRt = 3'($urandom_range(0, 3));
            IFIDrs = 3'($urandom_range(0, 3));
            IFIDrt = 3'($urandom_range(0, 3));
            IFID_UsesRt = $urandom_range(0, 1);
            IFID_IsMulDiv = ($urandom_range(0, 3) == 0);
            IFID_IsHiLo = ($urandom_range(0, 3) == 0);
            muldiv_start = (md_left == 0) && ($urandom_range(0, 5) == 0);
            muldiv_op = $urandom_range(0, 1);
            branch_taken = ($urandom_range(0, 7) == 0);
            step($sformatf("rand%0d", i));
        end

        // Saturation: hold a load-use hazard for 2^16+3 cycles.
        idle(); rst = 1; step("sat_rst");
        idle(); IDEX_MemRead = 1; IDEX_RegRt = 7; IFIDrs = 7;
        for (int i = 0; i < 65539; i++) step("sat");
        idle(); step("sat_end");
        check("sat_cnt", 32'(stall_cycles), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
